// File: rtl/risc16_run_ctrl.sv
// Run/halt/step sequencer gating the Risc16 datapath clock-enable.
// Optional retired-instruction counter enabled by defining RUN_CTRL_ICOUNT_EN.
module risc16_run_ctrl #(
   parameter int PC_W      = 16,
   parameter int CNT_W     = 8,
   parameter bit START_RUN = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [1:0]      cmd_op,
   input  logic [15:0]     cmd_data,
   input  logic            bp_en,
   input  logic [PC_W-1:0] bp_addr,
   input  logic [PC_W-1:0] pc_current,
   output logic            cpu_en,
   output logic            pc_load,
   output logic [PC_W-1:0] pc_load_val,
   output logic            halted,
   output logic [1:0]      halt_cause,
   output logic            cmd_err,
   output logic [31:0]     icount
);

   typedef enum logic [1:0] {
      S_HALTED = 2'd0,
      S_RUN    = 2'd1,
      S_STEP   = 2'd2,
      S_LOADPC = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      C_RESET = 2'd0,
      C_HALT  = 2'd1,
      C_BP    = 2'd2,
      C_STEP  = 2'd3
   } cause_t;

   localparam logic [1:0] OP_HALT  = 2'd0;
   localparam logic [1:0] OP_RUN   = 2'd1;
   localparam logic [1:0] OP_STEP  = 2'd2;
   localparam logic [1:0] OP_SETPC = 2'd3;

   state_t           state;
   cause_t           cause_q;
   logic             bp_skip;
   logic [CNT_W-1:0] step_cnt;

   logic             cmd_acc;
   logic             halt_acc;
   logic             bp_hit;
   logic [CNT_W-1:0] step_req;

   assign cmd_ready = (state == S_HALTED) || (state == S_RUN);
   assign cmd_acc   = cmd_valid && cmd_ready;
   assign halt_acc  = cmd_acc && (cmd_op == OP_HALT);
   assign bp_hit    = (state == S_RUN) && bp_en && (pc_current == bp_addr) && !bp_skip;
   assign step_req  = (cmd_data[CNT_W-1:0] == '0) ? CNT_W'(1) : cmd_data[CNT_W-1:0];

   // cpu_en is decoded from the registered state so a stop request or a
   // breakpoint suppresses the instruction at pc_current in the same cycle.
   assign cpu_en     = (state == S_STEP) || ((state == S_RUN) && !bp_hit && !halt_acc);
   assign pc_load    = (state == S_LOADPC);
   assign halted     = (state == S_HALTED);
   assign halt_cause = cause_q;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // branch below reads the pre-edge values of state, step_cnt and bp_skip.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= START_RUN ? S_RUN : S_HALTED;
         cause_q     <= C_RESET;
         bp_skip     <= 1'b0;
         step_cnt    <= '0;
         pc_load_val <= '0;
         cmd_err     <= 1'b0;
      end else begin
         cmd_err <= cmd_acc && (state == S_RUN) && (cmd_op != OP_HALT);
         case (state)
            S_HALTED: begin
               if (cmd_acc) begin
                  case (cmd_op)
                     OP_RUN: begin
                        state   <= S_RUN;
                        bp_skip <= 1'b1;
                     end
                     OP_STEP: begin
                        state    <= S_STEP;
                        step_cnt <= step_req;
                     end
                     OP_SETPC: begin
                        state       <= S_LOADPC;
                        pc_load_val <= cmd_data[PC_W-1:0];
                     end
                     default: ;
                  endcase
               end
            end
            S_RUN: begin
               bp_skip <= 1'b0;
               if (bp_hit) begin
                  state   <= S_HALTED;
                  cause_q <= C_BP;
               end else if (halt_acc) begin
                  state   <= S_HALTED;
                  cause_q <= C_HALT;
               end
            end
            S_STEP: begin
               // The counter parks at 1 on the final step instead of wrapping.
               if (step_cnt <= CNT_W'(1)) begin
                  state   <= S_HALTED;
                  cause_q <= C_STEP;
               end else begin
                  step_cnt <= step_cnt - CNT_W'(1);
               end
            end
            S_LOADPC: begin
               state <= S_HALTED;
            end
            default: state <= S_HALTED;
         endcase
      end
   end

`ifdef RUN_CTRL_ICOUNT_EN
   logic [31:0] icount_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         icount_q <= '0;
      end else if (pc_load) begin
         icount_q <= '0;
      end else if (cpu_en && (icount_q != 32'hFFFF_FFFF)) begin
         icount_q <= icount_q + 32'd1;
      end
   end

   assign icount = icount_q;
`else
   assign icount = 32'd0;
`endif

endmodule

// File: tb/tb_risc16_run_ctrl.sv
// Self-checking bench for risc16_run_ctrl: directed test-plan scenarios plus
// randomized commands checked against a cycle-level behavioural model.
module tb_risc16_run_ctrl;

   localparam int PC_W  = 16;
   localparam int CNT_W = 8;

   localparam logic [1:0] OP_HALT  = 2'd0;
   localparam logic [1:0] OP_RUN   = 2'd1;
   localparam logic [1:0] OP_STEP  = 2'd2;
   localparam logic [1:0] OP_SETPC = 2'd3;

   localparam int M_HALTED = 0;
   localparam int M_RUN    = 1;
   localparam int M_STEP   = 2;
   localparam int M_LOADPC = 3;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            cmd_valid = 1'b0;
   logic [1:0]      cmd_op = 2'd0;
   logic [15:0]     cmd_data = 16'd0;
   logic            bp_en = 1'b0;
   logic [PC_W-1:0] bp_addr = '0;
   logic [PC_W-1:0] pc;
   logic            cmd_ready, cpu_en, pc_load, halted, cmd_err;
   logic [PC_W-1:0] pc_load_val;
   logic [1:0]      halt_cause;
   logic [31:0]     icount;

   always #5 clk = ~clk;

   risc16_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .START_RUN(1'b0)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
      .bp_en(bp_en), .bp_addr(bp_addr), .pc_current(pc),
      .cpu_en(cpu_en), .pc_load(pc_load), .pc_load_val(pc_load_val),
      .halted(halted), .halt_cause(halt_cause), .cmd_err(cmd_err), .icount(icount)
   );

   // Stand-in datapath PC: loads on pc_load, advances on cpu_en.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)       pc <= '0;
      else if (pc_load) pc <= pc_load_val;
      else if (cpu_en)  pc <= pc + 16'd1;
   end

   int errors = 0;
   int checks = 0;
   int en_cycles = 0;

   int          m_mode;
   bit          m_skip;
   int          m_left;
   logic [1:0]  m_cause;
   bit          m_err;
   logic [15:0] m_plv;
   longint      m_icount;

   logic [22:0] obs_v, exp_v;
   logic [31:0] obs_ic, exp_ic;

   task automatic model_reset();
      m_mode = M_HALTED; m_skip = 0; m_left = 0; m_cause = 2'd0;
      m_err = 0; m_plv = 16'd0; m_icount = 0;
   endtask

   // One clock cycle: drive a command, sample DUT and model before the edge,
   // then advance the model across the edge. Returns at the next falling edge.
   task automatic tick(input bit v, input logic [1:0] op, input logic [15:0] d);
      bit ready, acc, bp, en;
      cmd_valid = v; cmd_op = op; cmd_data = d;
      #1;
      ready = (m_mode == M_HALTED) || (m_mode == M_RUN);
      acc   = v && ready;
      bp    = (m_mode == M_RUN) && bp_en && (pc == bp_addr) && !m_skip;
      en    = (m_mode == M_STEP) || ((m_mode == M_RUN) && !bp && !(acc && op == OP_HALT));
      exp_v = {ready, en, (m_mode == M_LOADPC), (m_mode == M_HALTED), m_cause, m_err, m_plv};
      obs_v = {cmd_ready, cpu_en, pc_load, halted, halt_cause, cmd_err, pc_load_val};
`ifdef RUN_CTRL_ICOUNT_EN
      exp_ic = m_icount[31:0];
`else
      exp_ic = 32'd0;
`endif
      obs_ic = icount;
      en_cycles += int'(cpu_en);
      @(posedge clk);
      m_err = acc && (m_mode == M_RUN) && (op != OP_HALT);
      if (en && m_icount < 64'hFFFF_FFFF) m_icount++;
      if (m_mode == M_LOADPC) m_icount = 0;
      case (m_mode)
         M_HALTED: if (acc) begin
            if (op == OP_RUN) begin m_mode = M_RUN; m_skip = 1; end
            else if (op == OP_STEP) begin
               m_mode = M_STEP;
               m_left = (d[CNT_W-1:0] == 0) ? 1 : int'(d[CNT_W-1:0]);
            end
            else if (op == OP_SETPC) begin m_mode = M_LOADPC; m_plv = d; end
         end
         M_RUN: begin
            m_skip = 0;
            if (bp) begin m_mode = M_HALTED; m_cause = 2'd2; end
            else if (acc && op == OP_HALT) begin m_mode = M_HALTED; m_cause = 2'd1; end
         end
         M_STEP: begin
            m_left--;
            if (m_left == 0) begin m_mode = M_HALTED; m_cause = 2'd3; end
         end
         default: m_mode = M_HALTED;
      endcase
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if ({cmd_ready, cpu_en, pc_load, halted, halt_cause, cmd_err, pc_load_val} !== 23'b1_0_0_1_00_0_0000000000000000) begin
         errors++;
         $display("FAIL reset_state: got %b want 10010000000000000000000",
                  {cmd_ready, cpu_en, pc_load, halted, halt_cause, cmd_err, pc_load_val});
      end
      checks++;
      if (icount !== 32'd0) begin errors++; $display("FAIL reset_icount: got %0d want 0", icount); end
      @(negedge clk);
   endtask

   task automatic test_step();
      do_reset();
      en_cycles = 0;
      for (int i = 0; i < 6; i++) begin
         if (i == 0) tick(1'b1, OP_STEP, 16'd3); else tick(1'b0, OP_HALT, 16'd0);
         checks++;
         if (obs_v !== exp_v) begin errors++; $display("FAIL step3 cyc%0d: got %h want %h", i, obs_v, exp_v); end
      end
      checks++;
      if (en_cycles != 3 || pc !== 16'd3 || halted !== 1'b1 || halt_cause !== 2'd3) begin
         errors++;
         $display("FAIL step3_result: en=%0d pc=%0d halted=%b cause=%0d want en=3 pc=3 halted=1 cause=3",
                  en_cycles, pc, halted, halt_cause);
      end
   endtask

   task automatic test_setpc();
      tick(1'b1, OP_SETPC, 16'd12);
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL setpc_accept: got %h want %h", obs_v, exp_v); end
      tick(1'b0, OP_HALT, 16'd0);
      checks++;
      if (pc_load !== 1'b0 || obs_v[20] !== 1'b1 || obs_v[21] !== 1'b0 || obs_v[15:0] !== 16'd12) begin
         errors++;
         $display("FAIL setpc_pulse: pc_load=%b cpu_en=%b val=%0d want 1 0 12", obs_v[20], obs_v[21], obs_v[15:0]);
      end
      for (int i = 0; i < 4; i++) begin
         if (i == 0) tick(1'b1, OP_STEP, 16'd1); else tick(1'b0, OP_HALT, 16'd0);
         checks++;
         if (obs_v !== exp_v || obs_ic !== exp_ic) begin
            errors++; $display("FAIL setpc_step cyc%0d: got %h/%0d want %h/%0d", i, obs_v, obs_ic, exp_v, exp_ic);
         end
      end
      checks++;
      if (pc !== 16'd13) begin errors++; $display("FAIL setpc_pc: got %0d want 13", pc); end
   endtask

   task automatic test_breakpoint();
      int n;
      do_reset();
      bp_en = 1'b1; bp_addr = 16'd5;
      tick(1'b1, OP_RUN, 16'd0);
      n = 0;
      while (halted !== 1'b1 && n < 30) begin
         tick(1'b0, OP_HALT, 16'd0);
         checks++;
         if (obs_v !== exp_v) begin errors++; $display("FAIL bp_run cyc%0d: got %h want %h", n, obs_v, exp_v); end
         n++;
      end
      checks++;
      if (halted !== 1'b1 || pc !== 16'd5 || halt_cause !== 2'd2) begin
         errors++; $display("FAIL bp_halt: halted=%b pc=%0d cause=%0d want 1 5 2", halted, pc, halt_cause);
      end
      tick(1'b1, OP_RUN, 16'd0);
      tick(1'b0, OP_HALT, 16'd0);
      checks++;
      if (obs_v !== exp_v || pc !== 16'd6) begin
         errors++; $display("FAIL bp_resume: got %h pc=%0d want %h pc=6", obs_v, pc, exp_v);
      end
      tick(1'b1, OP_HALT, 16'd0);
      bp_en = 1'b0;
   endtask

   task automatic test_halt_and_errors();
      int n;
      do_reset();
      tick(1'b1, OP_RUN, 16'd0);
      n = 0;
      while (pc !== 16'd7 && n < 30) begin tick(1'b0, OP_HALT, 16'd0); n++; end
      tick(1'b1, OP_HALT, 16'd0);
      checks++;
      if (obs_v !== exp_v || obs_v[21] !== 1'b0) begin errors++; $display("FAIL halt_accept: got %h want %h", obs_v, exp_v); end
      checks++;
      if (pc !== 16'd7 || halted !== 1'b1 || halt_cause !== 2'd1) begin
         errors++; $display("FAIL halt_state: pc=%0d halted=%b cause=%0d want 7 1 1", pc, halted, halt_cause);
      end
      tick(1'b1, OP_RUN, 16'd0);
      tick(1'b1, OP_SETPC, 16'h0099);
      tick(1'b0, OP_HALT, 16'd0);
      checks++;
      if (obs_v !== exp_v || cmd_err !== 1'b0 || obs_v[19] !== 1'b0 || obs_v[16] !== 1'b1) begin
         errors++; $display("FAIL run_cmd_err: got %h want %h", obs_v, exp_v);
      end
      tick(1'b1, OP_HALT, 16'd0);
      en_cycles = 0;
      tick(1'b1, OP_STEP, 16'd5);
      tick(1'b1, OP_STEP, 16'd2);
      checks++;
      if (obs_v !== exp_v || obs_v[22] !== 1'b0) begin errors++; $display("FAIL step_busy: got %h want %h", obs_v, exp_v); end
      n = 0;
      while (halted !== 1'b1 && n < 20) begin tick(1'b0, OP_HALT, 16'd0); n++; end
      checks++;
      if (en_cycles != 5 || halt_cause !== 2'd3) begin
         errors++; $display("FAIL step_busy_count: en=%0d cause=%0d want 5 3", en_cycles, halt_cause);
      end
   endtask

   task automatic test_reset_mid_step();
      do_reset();
      tick(1'b1, OP_STEP, 16'd10);
      for (int i = 0; i < 4; i++) tick(1'b0, OP_HALT, 16'd0);
      checks++;
      if (pc !== 16'd4 || cpu_en !== 1'b1) begin errors++; $display("FAIL midstep_pre: pc=%0d cpu_en=%b want 4 1", pc, cpu_en); end
`ifdef RUN_CTRL_ICOUNT_EN
      checks++;
      if (icount !== 32'd4) begin errors++; $display("FAIL midstep_icount: got %0d want 4", icount); end
`endif
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({cpu_en, halted, halt_cause, icount} !== {1'b0, 1'b1, 2'd0, 32'd0}) begin
         errors++; $display("FAIL midstep_reset: cpu_en=%b halted=%b cause=%0d icount=%0d want 0 1 0 0",
                            cpu_en, halted, halt_cause, icount);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic [1:0]  op;
      logic [15:0] d;
      bit          v;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         if (i % 40 == 0) begin
            bp_en   = ($urandom_range(0, 1) == 1);
            bp_addr = 16'($urandom_range(0, 24));
         end
         v  = ($urandom_range(0, 2) == 0);
         op = 2'($urandom_range(0, 3));
         d  = (op == OP_SETPC) ? 16'($urandom_range(0, 24)) : 16'($urandom_range(0, 6));
         if ($urandom_range(0, 15) == 0) d = 16'h0100;
         tick(v, op, d);
         checks++;
         if (obs_v !== exp_v || obs_ic !== exp_ic) begin
            errors++; $display("FAIL random cyc%0d: got %h/%0d want %h/%0d", i, obs_v, obs_ic, exp_v, exp_ic);
         end
      end
      bp_en = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_step();
      test_setpc();
      test_breakpoint();
      test_halt_and_errors();
      test_reset_mid_step();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/risc16_run_ctrl.md
Name: risc16_run_ctrl

Overview:
Run/halt/step sequencer for the single-cycle Risc16 datapath. It drives a clock-enable to the datapath so the bench or a debug host can do the following:
- free-run the processor
- halt it on command or on a PC breakpoint
- single- or multi-step it
- force a new PC

It sits between the top level and the datapath. It observes pc_current and gates instruction execution. It never touches the register file or the memories.

Parameters:
PC_W, 16, width of PC / breakpoint / SETPC target
CNT_W, 8, width of step counter (taken from cmd_data[CNT_W-1:0])
START_RUN, 0, 1 = leave reset in RUN instead of HALTED

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at rising edge
cmd_op  in  2  0=HALT, 1=RUN, 2=STEP, 3=SETPC
cmd_data  in  16  STEP: count in [CNT_W-1:0]; SETPC: target in [PC_W-1:0]
bp_en  in  1  breakpoint enable
bp_addr  in  PC_W  breakpoint PC
pc_current  in  PC_W  datapath current PC
cpu_en  out  1  datapath executes instruction at pc_current on the next rising edge when 1
pc_load  out  1  one-cycle pulse: datapath loads pc_load_val into PC
pc_load_val  out  PC_W  SETPC target, registered
halted  out  1  state == HALTED
halt_cause  out  2  0=reset, 1=HALT cmd, 2=breakpoint, 3=step done
cmd_err  out  1  one-cycle pulse: accepted command was illegal in the current state
icount  out  32  retired-instruction count (see Optional Feature)

Behaviour:
Reset (async, rst_n=0):
- State = HALTED, or RUN if START_RUN=1.
- cpu_en=0, pc_load=0, pc_load_val=0, halt_cause=0, cmd_err=0, step counter=0, bp_skip=0.
- Reset mid-RUN or mid-STEP aborts immediately. No further cpu_en cycles occur.

States: HALTED, RUN, STEP, LOADPC.

cmd_ready:
- 1 in HALTED and RUN.
- 0 in STEP and LOADPC.

HALTED (cpu_en=0):
- RUN → RUN. Sets bp_skip=1.
- STEP → STEP. Counter = cmd_data count; a count of 0 is treated as 1.
- SETPC → LOADPC. pc_load_val = target.
- HALT → stays HALTED, no-op. halt_cause is unchanged.

RUN:
- bp_hit = bp_en && pc_current==bp_addr && !bp_skip.
- cpu_en = !bp_hit && !(cmd accepted with op HALT). The HALT term is combinational, so the instruction at the current PC does not execute.
- On bp_hit → HALTED, halt_cause=2.
- On accepted HALT → HALTED, halt_cause=1.
- If bp_hit and HALT occur in the same cycle, breakpoint wins (cause=2).
- bp_skip clears after the first RUN cycle. This lets a resume from a breakpoint execute the breakpointed instruction.
- Accepted RUN/STEP/SETPC in RUN: ignored, cmd_err pulses, state stays RUN.

STEP:
- cpu_en=1 every cycle. Breakpoints are ignored.
- Counter decrements on each cycle. The cycle where counter==1 is the last → HALTED, halt_cause=3.
- N steps give exactly N cpu_en cycles.

LOADPC:
- One cycle, pc_load=1, cpu_en=0 → HALTED. halt_cause unchanged.

General:
- cpu_en and pc_load are never both 1.
- Step counter arithmetic is CNT_W-bit unsigned with no wrap. It stops at 1.

Optional Feature:
Macro RUN_CTRL_ICOUNT_EN.
- Defined: icount is a 32-bit counter. It increments on every rising edge with cpu_en=1, saturates at 32'hFFFF_FFFF, and clears on reset and on LOADPC.
- Undefined: icount is tied to 0 and no counter flops are generated.

Test Plan:
- Reset, then STEP with cmd_data=3 → cpu_en high for exactly 3 cycles; then halted=1, halt_cause=3; PC advances 0→3.
- SETPC with cmd_data=12, then STEP 1 → pc_load pulses one cycle with pc_load_val=12, cpu_en=0 that cycle; the step executes PC 12 and PC becomes 13.
- bp_en=1, bp_addr=5, RUN from PC 0 → cpu_en for PC 0..4, halts with pc_current=5, halt_cause=2; a following RUN executes PC 5 (bp_skip) and continues to 6.
- RUN, then HALT while at PC 7 → cpu_en=0 in the accept cycle, PC stays 7, halt_cause=1; STEP issued during STEP sees cmd_ready=0; SETPC issued in RUN → cmd_err pulse, RUN continues.
- rst_n low during STEP with count 10 after 4 steps → cpu_en=0 asynchronously, halted=1, halt_cause=0; with RUN_CTRL_ICOUNT_EN defined, icount=4 before reset and 0 after.
